uart_rx: RTL and testbench

//  Hardware UART receiver (8N1, LSB first) for the SoC, paired with the existing uart_tx.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync2.sv | 24 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 347;
    localparam int UART_DATA_W          = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; RESET_VAL sets the
// value both flops take while in reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_core,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples the RX pin mid-bit and delivers bytes into a
// one-deep holding register with framing/overrun flags and cts_n flow control.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk_core,
    input  logic                   reset_n,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    input  logic                   err_clear,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   cts_n
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_W);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(UART_DATA_W - 1);

    rx_state_t              state, state_next;
    logic [CNT_W-1:0]       timer, timer_next;
    logic [IDX_W-1:0]       bit_idx, bit_idx_next;
    logic [UART_DATA_W-1:0] shreg, shreg_next;
    logic                   rx_s;
    logic                   tick;
    logic                   deliver;
    logic                   frame_set;
    logic                   pop;
    logic                   accept;

    sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .d        (rx),
        .q        (rx_s)
    );

    assign tick   = (timer == '0);
    assign pop    = rx_valid && rx_ready;
    assign accept = deliver && (!rx_valid || rx_ready);

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    // The timer saturates at zero; every state entry reloads it first.
    always_comb begin
        state_next   = state;
        timer_next   = tick ? '0 : timer - CNT_W'(1);
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        deliver      = 1'b0;
        frame_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    timer_next = HALF_RELOAD;
                end
            end
            START: begin
                if (tick) begin
                    timer_next = FULL_RELOAD;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_next = {rx_s, shreg[UART_DATA_W-1:1]};
                    timer_next = FULL_RELOAD;
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    timer_next = FULL_RELOAD;
                    if (rx_s) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                    timer_next = FULL_RELOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register and sticky flags; a new error event beats err_clear.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            cts_n     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                cts_n    <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
                cts_n    <= 1'b0;
            end
            frame_err <= frame_set | (frame_err & ~err_clear);
            overrun   <= (deliver & ~accept) | (overrun & ~err_clear);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// compared every cycle against a frame-level model of the holding register.
module tb_uart_rx;

    localparam int BIT_CLKS  = 16;
    localparam int FRAME_LAT = 9 * BIT_CLKS + BIT_CLKS / 2 + 3;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic        good;
    } frame_evt_t;

    logic       clk_core = 1'b0;
    logic       reset_n  = 1'b0;
    logic       rx       = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_clear;
    logic       frame_err;
    logic       overrun;
    logic       cts_n;

    logic ready_req  = 1'b0;
    logic clear_req  = 1'b0;
    logic rand_en    = 1'b0;
    logic rand_ready = 1'b0;
    logic rand_clear = 1'b0;
    logic check_en   = 1'b0;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    frame_evt_t evq[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ferr  = 1'b0;
    logic       m_over  = 1'b0;
    logic       m_pop, m_next_valid, m_set_f, m_set_o;
    frame_evt_t m_ev;

    assign rx_ready  = rand_en ? rand_ready : ready_req;
    assign err_clear = rand_en ? rand_clear : clear_req;

    uart_rx #(.CLKS_PER_BIT(BIT_CLKS)) dut (
        .clk_core  (clk_core),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_clear (err_clear),
        .frame_err (frame_err),
        .overrun   (overrun),
        .cts_n     (cts_n)
    );

    always #5 clk_core = ~clk_core;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Drives the first nbits of a start/data/stop frame; call on a falling clock edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int nbits);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        if (nbits == 10) begin
            evq.push_back('{cyc + FRAME_LAT, data, stop_bit});
        end
        for (int i = 0; i < nbits; i++) begin
            rx = frame[i];
            repeat (BIT_CLKS) @(negedge clk_core);
        end
    endtask

    task automatic popByte();
        ready_req = 1'b1;
        @(negedge clk_core);
        ready_req = 1'b0;
    endtask

    task automatic clearErr();
        clear_req = 1'b1;
        @(negedge clk_core);
        clear_req = 1'b0;
    endtask

    // Frame-level reference: each completed frame lands in the holding register
    // (or raises a flag) on its completion clock.
    always @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ferr  = 1'b0;
            m_over  = 1'b0;
            evq.delete();
        end else begin
            cyc++;
            m_pop        = m_valid && rx_ready;
            m_next_valid = m_valid && !m_pop;
            m_set_f      = 1'b0;
            m_set_o      = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                m_ev = evq.pop_front();
                if (!m_ev.good) begin
                    m_set_f = 1'b1;
                end else if (!m_valid || m_pop) begin
                    m_data       = m_ev.data;
                    m_next_valid = 1'b1;
                end else begin
                    m_set_o = 1'b1;
                end
            end
            if (err_clear) begin
                m_ferr = 1'b0;
                m_over = 1'b0;
            end
            if (m_set_f) m_ferr = 1'b1;
            if (m_set_o) m_over = 1'b1;
            m_valid = m_next_valid;
        end
    end

    always @(negedge clk_core) begin
        rand_ready = ($urandom_range(0, 3) == 0);
        rand_clear = ($urandom_range(0, 31) == 0);
        if (check_en) begin
            checkOutput("valid", rx_valid, m_valid);
            checkOutput("data", rx_data, m_data);
            checkOutput("frame_err", frame_err, m_ferr);
            checkOutput("overrun", overrun, m_over);
            checkOutput("cts_n", cts_n, m_valid);
        end
    end

    initial begin
        logic [7:0] d;
        logic       good;

        repeat (3) @(negedge clk_core);
        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_data", rx_data, 8'h00);
        checkOutput("reset_cts", cts_n, 0);
        checkOutput("reset_flags", {frame_err, overrun}, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_core);
        check_en = 1'b1;

        $display("[TB] scenario 1: single byte, latency, pop");
        fork
            applyStimulus(8'hA5, 1'b1, 10);
            begin
                repeat (FRAME_LAT - 1) @(negedge clk_core);
                checkOutput("t1_valid_early", rx_valid, 0);
                @(negedge clk_core);
                checkOutput("t1_valid_on_time", rx_valid, 1);
                checkOutput("t1_data", rx_data, 8'hA5);
                checkOutput("t1_cts", cts_n, 1);
            end
        join
        popByte();
        checkOutput("t1_valid_after_pop", rx_valid, 0);
        checkOutput("t1_cts_after_pop", cts_n, 0);
        checkOutput("t1_data_held", rx_data, 8'hA5);

        $display("[TB] scenario 2: idle glitch");
        rx = 1'b0;
        repeat (4) @(negedge clk_core);
        rx = 1'b1;
        repeat (30) @(negedge clk_core);
        checkOutput("t2_no_valid", rx_valid, 0);
        checkOutput("t2_no_flag", {frame_err, overrun}, 0);
        applyStimulus(8'h3C, 1'b1, 10);
        checkOutput("t2_data", rx_data, 8'h3C);
        popByte();

        $display("[TB] scenario 3: framing error and break");
        applyStimulus(8'hFF, 1'b0, 10);
        repeat (40) @(negedge clk_core);
        checkOutput("t3_ferr", frame_err, 1);
        checkOutput("t3_no_valid", rx_valid, 0);
        rx = 1'b1;
        repeat (20) @(negedge clk_core);
        applyStimulus(8'h01, 1'b1, 10);
        checkOutput("t3_after_break", rx_data, 8'h01);
        checkOutput("t3_after_break_valid", rx_valid, 1);
        popByte();
        clearErr();
        checkOutput("t3_ferr_cleared", frame_err, 0);

        $display("[TB] scenario 4: overrun and same-cycle pop");
        applyStimulus(8'h11, 1'b1, 10);
        applyStimulus(8'h22, 1'b1, 10);
        checkOutput("t4_kept_old", rx_data, 8'h11);
        checkOutput("t4_overrun", overrun, 1);
        popByte();
        clearErr();
        fork
            begin
                applyStimulus(8'h11, 1'b1, 10);
                applyStimulus(8'h22, 1'b1, 10);
            end
            begin
                repeat (BIT_CLKS * 10 + FRAME_LAT - 1) @(negedge clk_core);
                ready_req = 1'b1;
                @(negedge clk_core);
                ready_req = 1'b0;
            end
        join
        checkOutput("t4_pop_data", rx_data, 8'h22);
        checkOutput("t4_pop_valid", rx_valid, 1);
        checkOutput("t4_pop_no_overrun", overrun, 0);
        popByte();

        $display("[TB] scenario 5: reset mid-frame");
        applyStimulus(8'h5A, 1'b1, 5);
        rx = 1'b1;
        repeat (3) @(negedge clk_core);
        check_en = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", rx_valid, 0);
        checkOutput("t5_rst_data", rx_data, 8'h00);
        checkOutput("t5_rst_cts", cts_n, 0);
        checkOutput("t5_rst_flags", {frame_err, overrun}, 0);
        repeat (2) @(negedge clk_core);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_core);
        check_en = 1'b1;
        applyStimulus(8'h5A, 1'b1, 10);
        checkOutput("t5_data", rx_data, 8'h5A);
        checkOutput("t5_flags", {frame_err, overrun}, 0);
        popByte();

        $display("[TB] scenario 6: err_clear coincides with framing error");
        fork
            applyStimulus(8'h96, 1'b0, 10);
            begin
                repeat (FRAME_LAT - 1) @(negedge clk_core);
                clear_req = 1'b1;
                @(negedge clk_core);
                clear_req = 1'b0;
            end
        join
        rx = 1'b1;
        checkOutput("t6_set_wins", frame_err, 1);
        repeat (10) @(negedge clk_core);
        clearErr();

        $display("[TB] randomized frames");
        rand_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            applyStimulus(d, good, 10);
            rx = 1'b1;
            repeat (good ? $urandom_range(0, 20) : $urandom_range(4, 30)) @(negedge clk_core);
        end
        rand_en = 1'b0;
        repeat (40) @(negedge clk_core);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
